// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch sequencing block.
// Holds the sequencer state encoding, MIPS-style compare codes and the link register index.
// Pure declarations; no logic, no latency, no flow control.
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_RESOLVE  = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    localparam logic [2:0] BR_BEQ    = 3'b000;
    localparam logic [2:0] BR_BNE    = 3'b001;
    localparam logic [2:0] BR_BGEZ   = 3'b010;
    localparam logic [2:0] BR_BGTZ   = 3'b011;
    localparam logic [2:0] BR_BLEZ   = 3'b100;
    localparam logic [2:0] BR_BLTZ   = 3'b101;
    localparam logic [2:0] BR_BGEZAL = 3'b110;
    localparam logic [2:0] BR_BLTZAL = 3'b111;

    // Architectural register written by the and-link branch variants.
    localparam int unsigned LINK_REG = 31;

    // True for the compare codes that also write the return address.
    function automatic logic is_link(input logic [2:0] code);
        return (code == BR_BGEZAL) || (code == BR_BLTZAL);
    endfunction

endpackage

// File: rtl/branch_ctrl_bcnt_sat.sv
// Saturating up-counter with synchronous clear, used for branch statistics.
// Latency: count visible one cycle after the increment/clear request.
// No backpressure; clear takes priority over increment, count sticks at all-ones.
module bcnt_sat #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear first, then increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage conditional branch sequencer: waits out operand hazards, drives the external comparator, redirects on taken.
// Latency: accept -> redirect_valid in 2 cycles when operands are ready; plus one cycle per busy cycle otherwise.
// Backpressure: stall_id holds PC and IF/ID while a branch is pending; inputs ignored outside IDLE.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic [31:0]      br_pc,
    input  logic [15:0]      br_imm,
    input  logic             rs_busy,
    input  logic             rt_busy,
    output logic [2:0]       cmpctr,
    input  logic             branch_used,
    output logic             stall_id,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_if,
    output logic             link_we,
    output logic [31:0]      link_data,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    state_t      state_q, state_d;
    logic [2:0]  type_q;
    logic [31:0] pc_q;
    logic [15:0] imm_q;

    logic        busy;
    logic        accept;
    logic        in_resolve;
    logic [31:0] target;

    assign busy       = rs_busy | rt_busy;
    assign accept     = (state_q == ST_IDLE) && br_valid;
    assign in_resolve = (state_q == ST_RESOLVE);

    // Next-state selection; br_valid only matters in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (br_valid) state_d = busy ? ST_WAIT : ST_RESOLVE;
            ST_WAIT:     if (!busy) state_d = ST_RESOLVE;
            ST_RESOLVE:  state_d = branch_used ? ST_REDIRECT : ST_IDLE;
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the branch fields once on acceptance; they stay frozen until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_q <= '0;
            pc_q   <= '0;
            imm_q  <= '0;
        end else if (accept) begin
            type_q <= br_type;
            pc_q   <= br_pc;
            imm_q  <= br_imm;
        end
    end

    // Branch target: delay-slot PC plus word-scaled signed offset, wrapping at 2^32.
    assign target = pc_q + 32'd4 + {{14{imm_q[15]}}, imm_q, 2'b00};

    // Outputs are forced quiet while reset is held, including the datapath values.
    assign cmpctr         = type_q;
    assign stall_id       = !rst && ((state_q == ST_WAIT) || in_resolve ||
                                     ((state_q == ST_IDLE) && br_valid));
    assign redirect_valid = !rst && (state_q == ST_REDIRECT);
    assign flush_if       = redirect_valid;
    assign redirect_pc    = rst ? 32'd0 : target;
    assign link_we        = !rst && in_resolve && is_link(type_q);
    assign link_data      = rst ? 32'd0 : (pc_q + 32'd8);

    bcnt_sat #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_cnt),
        .inc_i (in_resolve),
        .cnt_o (branch_cnt)
    );

    bcnt_sat #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_cnt),
        .inc_i (in_resolve && branch_used),
        .cnt_o (taken_cnt)
    );

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: directed scenarios plus randomized branches against a transaction-level model.
// Inputs driven just after the rising edge, outputs sampled on the falling edge.
// Counters built 4 bits wide so saturation is reached quickly.
module tb_branch_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          br_valid;
    logic [2:0]    br_type;
    logic [31:0]   br_pc;
    logic [15:0]   br_imm;
    logic          rs_busy, rt_busy;
    logic [2:0]    cmpctr;
    logic          branch_used;
    logic          stall_id;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          flush_if;
    logic          link_we;
    logic [31:0]   link_data;
    logic          clr_cnt;
    logic [CW-1:0] branch_cnt, taken_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int m_br     = 0;
    int m_tk     = 0;

    branch_ctrl #(.CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .br_valid       (br_valid),
        .br_type        (br_type),
        .br_pc          (br_pc),
        .br_imm         (br_imm),
        .rs_busy        (rs_busy),
        .rt_busy        (rt_busy),
        .cmpctr         (cmpctr),
        .branch_used    (branch_used),
        .stall_id       (stall_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if       (flush_if),
        .link_we        (link_we),
        .link_data      (link_data),
        .clr_cnt        (clr_cnt),
        .branch_cnt     (branch_cnt),
        .taken_cnt      (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One branch transaction from acceptance to the first idle cycle after it.
    // Expected behaviour is derived from the rules: accept cycle, one wait cycle per busy
    // cycle beyond the first (the last busy-low wait included), resolve, optional redirect.
    task automatic do_branch(input logic [2:0] t, input logic [31:0] pc, input logic [15:0] imm,
                             input int busy, input bit taken, input bit clr);
        int          rc, n_stall, n_redir, n_flush, n_link, redir_cyc, link_cyc;
        logic [31:0] got_rpc, got_ldata, exp_rpc, exp_ldata;
        logic [2:0]  got_cm;
        bit          use_rt, is_al;
        rc        = (busy > 0) ? busy + 1 : 1;
        use_rt    = 1'($urandom_range(0, 1));
        n_stall   = 0; n_redir = 0; n_flush = 0; n_link = 0;
        redir_cyc = -1; link_cyc = -1;
        got_rpc   = '0; got_ldata = '0; got_cm = '0;
        for (int c = 0; c <= rc + 2; c++) begin
            br_valid = (c == 0);
            if (c == 0) begin
                br_type = t; br_pc = pc; br_imm = imm;
            end else begin
                br_type = 3'($urandom_range(0, 7));
                br_pc   = $urandom;
                br_imm  = 16'($urandom);
            end
            rs_busy     = (c < busy) && !use_rt;
            rt_busy     = (c < busy) && use_rt;
            branch_used = (c == rc) ? taken : 1'($urandom_range(0, 1));
            clr_cnt     = clr;
            @(negedge clk);
            if (stall_id) n_stall++;
            if (redirect_valid) begin n_redir++; redir_cyc = c; got_rpc = redirect_pc; end
            if (flush_if) n_flush++;
            if (link_we) begin n_link++; link_cyc = c; got_ldata = link_data; end
            if (c == 1) got_cm = cmpctr;
            @(posedge clk); #1;
        end
        br_valid = 1'b0; rs_busy = 1'b0; rt_busy = 1'b0; clr_cnt = 1'b0; branch_used = 1'b0;

        exp_rpc   = 32'(longint'(pc) + 64'sd4 + 64'sd4 * longint'($signed(imm)));
        exp_ldata = 32'(longint'(pc) + 64'sd8);
        is_al     = (t == 3'd6) || (t == 3'd7);
        if (clr) begin
            m_br = 0; m_tk = 0;
        end else begin
            m_br = (m_br < CMAX) ? m_br + 1 : CMAX;
            if (taken) m_tk = (m_tk < CMAX) ? m_tk + 1 : CMAX;
        end

        check_eq("cmpctr", 32'(got_cm), 32'(t));
        check_eq("stall_cycles", 32'(n_stall), 32'(rc + 1));
        check_eq("redirect_count", 32'(n_redir), taken ? 32'd1 : 32'd0);
        check_eq("flush_count", 32'(n_flush), taken ? 32'd1 : 32'd0);
        if (taken) begin
            check_eq("redirect_latency", 32'(redir_cyc), 32'(rc + 1));
            check_eq("redirect_pc", got_rpc, exp_rpc);
        end
        check_eq("link_count", 32'(n_link), is_al ? 32'd1 : 32'd0);
        if (is_al) begin
            check_eq("link_cycle", 32'(link_cyc), 32'(rc));
            check_eq("link_data", got_ldata, exp_ldata);
        end
        check_eq("branch_cnt", 32'(branch_cnt), 32'(m_br));
        check_eq("taken_cnt", 32'(taken_cnt), 32'(m_tk));
    endtask

    initial begin
        rst = 1'b1; br_valid = 1'b1; br_type = 3'd5; br_pc = 32'h1234_5678; br_imm = 16'h8001;
        rs_busy = 1'b0; rt_busy = 1'b0; branch_used = 1'b1; clr_cnt = 1'b0;

        // Reset state, with br_valid high to make sure the stall path is quiet too.
        @(negedge clk);
        check_eq("rst_stall_id", 32'(stall_id), 32'd0);
        check_eq("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check_eq("rst_flush_if", 32'(flush_if), 32'd0);
        check_eq("rst_link_we", 32'(link_we), 32'd0);
        check_eq("rst_redirect_pc", redirect_pc, 32'd0);
        check_eq("rst_link_data", link_data, 32'd0);
        check_eq("rst_cmpctr", 32'(cmpctr), 32'd0);
        check_eq("rst_branch_cnt", 32'(branch_cnt), 32'd0);
        check_eq("rst_taken_cnt", 32'(taken_cnt), 32'd0);
        @(posedge clk); #1;
        br_valid = 1'b0; branch_used = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Idle with no branch: nothing asserted.
        @(negedge clk);
        check_eq("idle_stall_id", 32'(stall_id), 32'd0);
        check_eq("idle_redirect_valid", 32'(redirect_valid), 32'd0);
        @(posedge clk); #1;

        // Directed scenarios.
        do_branch(3'b000, 32'h0040_0000, 16'h0004, 0, 1'b1, 1'b0);  // beq taken, 0x00400014
        do_branch(3'b001, 32'h0040_0100, 16'h0010, 3, 1'b0, 1'b0);  // bne, 3 busy cycles, not taken
        do_branch(3'b111, 32'h0000_1000, 16'hFFFF, 0, 1'b1, 1'b0);  // bltzal taken, target 0x1000
        do_branch(3'b010, 32'hFFFF_FFF8, 16'h0001, 1, 1'b1, 1'b0);  // target wraps to 0
        do_branch(3'b110, 32'hFFFF_FFFC, 16'h0000, 2, 1'b0, 1'b0);  // bgezal not taken, link wraps

        // Drive the taken counter into saturation, then clear alongside a resolve.
        for (int i = 0; i < 16; i++)
            do_branch(3'($urandom_range(0, 7)), $urandom, 16'($urandom), 0, 1'b1, 1'b0);
        do_branch(3'b000, 32'h0000_2000, 16'h0002, 0, 1'b1, 1'b1);

        // Randomized branches.
        for (int i = 0; i < 40; i++)
            do_branch(3'($urandom_range(0, 7)), $urandom, 16'($urandom),
                      $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0));

        // Reset while resolving a taken and-link branch: abandoned without redirect or link.
        br_valid = 1'b1; br_type = 3'b111; br_pc = 32'h0000_3000; br_imm = 16'h0008;
        rs_busy = 1'b0; rt_busy = 1'b0; branch_used = 1'b1;
        @(posedge clk); #1;
        br_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_stall_id", 32'(stall_id), 32'd0);
        check_eq("midrst_redirect_valid", 32'(redirect_valid), 32'd0);
        check_eq("midrst_link_we", 32'(link_we), 32'd0);
        check_eq("midrst_redirect_pc", redirect_pc, 32'd0);
        check_eq("midrst_link_data", link_data, 32'd0);
        check_eq("midrst_cmpctr", 32'(cmpctr), 32'd0);
        check_eq("midrst_branch_cnt", 32'(branch_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_br = 0; m_tk = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("postrst_redirect_valid", 32'(redirect_valid), 32'd0);
            check_eq("postrst_link_we", 32'(link_we), 32'd0);
            check_eq("postrst_stall_id", 32'(stall_id), 32'd0);
        end
        check_eq("postrst_branch_cnt", 32'(branch_cnt), 32'(m_br));
        check_eq("postrst_taken_cnt", 32'(taken_cnt), 32'(m_tk));
        @(posedge clk); #1;

        // Controller is usable again after the abandoned branch.
        do_branch(3'b011, 32'h0000_4000, 16'h0003, 0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of performance counters.
REQ-002 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port br_valid  in  1  ID stage holds a conditional branch.
REQ-005 SHALL have port br_type  in  3  compare code: 000 beq, 001 bne, 010 bgez, 011 bgtz, 100 blez, 101 bltz, 110 bgezal, 111 bltzal.
REQ-006 SHALL have port br_pc  in  32  PC of the branch.
REQ-007 SHALL have port br_imm  in  16  branch offset field.
REQ-008 SHALL have port rs_busy / rt_busy  in  1 each  operand not yet forwardable (load-use pending).
REQ-009 SHALL have port cmpctr  out  3  compare code driven to the branch comparator.
REQ-010 SHALL have port branch_used  in  1  comparator result for current cmpctr.
REQ-011 SHALL have port stall_id  out  1  hold PC and IF/ID.
REQ-012 SHALL have ports redirect_valid (1) and redirect_pc (32), both out  taken-branch redirect.
REQ-013 SHALL have port flush_if  out  1  kill instruction in IF.
REQ-014 SHALL have ports link_we (1) and link_data (32), both out  $31 write for AL variants.
REQ-015 SHALL have port clr_cnt  in  1  synchronous counter clear.
REQ-016 SHALL have ports branch_cnt and taken_cnt, both out  CNT_W  performance counters.

Function
REQ-017 SHALL implement FSM IDLE, WAIT, RESOLVE, REDIRECT.
REQ-018 IDLE: br_valid & ~(rs_busy|rt_busy) -> RESOLVE; br_valid & busy -> WAIT; else stay.
REQ-019 SHALL latch br_type, br_pc, br_imm on leaving IDLE; inputs ignored until return to IDLE.
REQ-020 WAIT: -> RESOLVE in the cycle after both busy flags sample low; unbounded wait.
REQ-021 cmpctr SHALL be the registered latched type, updated on acceptance, constant until next acceptance.
REQ-022 RESOLVE: sample branch_used; 1 -> REDIRECT, 0 -> IDLE.
REQ-023 REDIRECT: single cycle, then IDLE.
REQ-024 stall_id SHALL be 1 in WAIT and RESOLVE, and combinationally in IDLE when br_valid=1; 0 otherwise.
REQ-025 redirect_valid and flush_if SHALL be 1 exactly during REDIRECT.
REQ-026 redirect_pc SHALL equal latched_pc + 4 + (sign_extend(imm) << 2), modulo 2^32 (wrap, no error).
REQ-027 link_we SHALL pulse 1 during RESOLVE for types 110/111 regardless of outcome; link_data = latched_pc + 8 modulo 2^32.
REQ-028 Minimum latency accept -> redirect_valid: 2 cycles (IDLE->RESOLVE->REDIRECT).
REQ-029 branch_cnt SHALL increment in RESOLVE; taken_cnt SHALL increment in RESOLVE when branch_used=1.
REQ-030 Counters SHALL saturate at all-ones, never wrap.
REQ-031 clr_cnt SHALL zero both counters next edge; clear wins over simultaneous increment.
REQ-032 br_valid in REDIRECT SHALL be ignored; re-evaluated in IDLE the next cycle.

Reset
REQ-033 rst SHALL force IDLE immediately, cmpctr=000, latched fields 0, counters 0.
REQ-034 During rst: stall_id, redirect_valid, flush_if, link_we = 0; redirect_pc, link_data = 0.
REQ-035 rst mid-WAIT/RESOLVE/REDIRECT SHALL abandon the branch with no redirect, link or count.

Structure
REQ-036 Shared package SHALL hold the state enum, 3-bit compare-code constants, and LINK_REG = 31.
REQ-037 Single sub-module bcnt_sat (saturating counter with clear, width CNT_W) SHALL be instantiated twice.
REQ-038 Comparator SHALL stay external; this block owns only sequencing.

Verification
REQ-039 beq, pc=0x00400000, imm=0x0004, no busy, branch_used=1 -> cmpctr=000, redirect_valid at cycle +2, redirect_pc=0x00400014, branch_cnt=1, taken_cnt=1.
REQ-040 bne, rs_busy high 3 cycles -> stall_id held 5 cycles total, branch_used=0 -> no redirect, taken_cnt unchanged.
REQ-041 bltzal, pc=0x00001000, imm=0xFFFF, taken -> link_we pulse with link_data=0x00001008, redirect_pc=0x00001000.
REQ-042 pc=0xFFFFFFF8, imm=0x0001, taken -> redirect_pc=0x00000000 (wrap).
REQ-043 CNT_W=4, 16 taken branches -> taken_cnt stays 0xF; clr_cnt with simultaneous RESOLVE -> both counters 0.
REQ-044 rst asserted in RESOLVE -> no redirect_valid, no link_we, state IDLE, all outputs 0.
